// File: rtl/lshift_arb.sv
// Two-requester arbiter in front of a single 4-bit left shifter with a LAT-cycle EXEC phase.
// Define LSHIFT_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.

module Lshift4 (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic [3:0] y
);
  assign y = a << s;
endmodule

module lshift_arb #(
  parameter int LAT = 1  // EXEC length in cycles, 1..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] A0,
  input  logic [3:0] A1,
  input  logic [1:0] shl0,
  input  logic [1:0] shl1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] OUT,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;

  localparam logic [1:0] CNT_LAST = 2'(LAT - 1);

  state_t     state, state_nx;
  logic [3:0] opA;
  logic [1:0] opS;
  logic [1:0] cnt;
  logic       win;
  logic       win_nx;
  logic       accept;
  logic [3:0] res;

  assign accept = (state == IDLE) && (req0 || req1);

  Lshift4 u_shift (
    .a (opA),
    .s (opS),
    .y (res)
  );

`ifdef LSHIFT_RR_EN
  logic last;  // id of the requester served most recently

  always_comb begin
    if (req0 && req1) win_nx = ~last;
    else              win_nx = ~req0;
  end

  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= win_nx;
  end
`else
  assign win_nx = ~req0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1)    state_nx = GRANT;
      GRANT:                        state_nx = EXEC;
      EXEC:    if (cnt == CNT_LAST) state_nx = DONE;
      DONE:                         state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = (state != IDLE);
    case (state)
      GRANT: begin
        gnt0 = ~win;
        gnt1 = win;
      end
      DONE: begin
        done0 = ~win;
        done1 = win;
      end
      default: ;
    endcase
  end

  // Operands are captured only on the accept edge, so later input changes cannot reach the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA <= '0;
      opS <= '0;
      win <= 1'b0;
      cnt <= '0;
      OUT <= '0;
    end else begin
      if (accept) begin
        opA <= win_nx ? A1 : A0;
        opS <= win_nx ? shl1 : shl0;
        win <= win_nx;
      end
      if (state == GRANT)
        cnt <= '0;
      else if (state == EXEC && cnt != CNT_LAST)
        cnt <= cnt + 2'd1;
      if (state == EXEC && cnt == CNT_LAST)
        OUT <= res;
    end
  end

endmodule
